// File: rtl/duty_step_ctrl_if.sv
// duty_step_ctrl_if
//   Groups the button inputs and duty outputs of duty_step_ctrl.
//   master : the side that presses buttons and consumes the duty value
//   slave  : the duty controller itself
//   btn_up / btn_dn : raw push-buttons, 1 = pressed
//   duty            : current duty value, 15 bits
//   duty_upd        : one-cycle pulse when duty takes a new value
//   at_max / at_min : duty at its upper limit / at zero
interface duty_step_ctrl_if;
  logic        btn_up;
  logic        btn_dn;
  logic [14:0] duty;
  logic        duty_upd;
  logic        at_max;
  logic        at_min;

  modport master (
    output btn_up, btn_dn,
    input  duty, duty_upd, at_max, at_min
  );

  modport slave (
    input  btn_up, btn_dn,
    output duty, duty_upd, at_max, at_min
  );
endinterface

// File: rtl/duty_step_ctrl.sv
// duty_step_ctrl
//   Two debounced push-buttons step a PWM duty value up or down by STEP,
//   saturating at 0 and MAX_DUTY. Each button is synchronized, then
//   qualified by a 4-state debounce FSM that emits one event per press.
// Ports
//   clk  : system clock, all state changes on its rising edge
//   rst  : asynchronous active-low reset
//   bus  : duty_step_ctrl_if.slave (btn_up, btn_dn in; duty, duty_upd,
//          at_max, at_min out)
module duty_step_ctrl #(
  parameter int DEB_CYCLES = 270000,
  parameter int STEP       = 2700,
  parameter int MAX_DUTY   = 27000,
  parameter int INIT_DUTY  = 13500
) (
  input  logic                    clk,
  input  logic                    rst,
  duty_step_ctrl_if.slave         bus
);

  // Counter holds 0..DEB_CYCLES-1; $clog2(N) bits are enough for N-1.
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
  localparam logic [14:0]   STEP_D  = 15'(STEP);
  localparam logic [14:0]   MAX_D   = 15'(MAX_DUTY);
  localparam logic [14:0]   INIT_D  = 15'(INIT_DUTY);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } deb_state_t;

  logic [1:0] btn_raw;   // [0] = up, [1] = down
  logic [1:0] press_ev;

  assign btn_raw = {bus.btn_dn, bus.btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic          sync1_reg;
      logic          sync2_reg;
      deb_state_t    state_reg;
      deb_state_t    state_next;
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;
      logic          ev;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          state_reg <= RELEASED;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
        end
      end

      // The counter only advances while below CNT_MAX, so it cannot wrap.
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ev         = 1'b0;
        case (state_reg)
          RELEASED: begin
            if (sync2_reg) begin
              state_next = PRESS_WAIT;
              cnt_next   = '0;
            end
          end
          PRESS_WAIT: begin
            if (!sync2_reg) begin
              state_next = RELEASED;
            end else if (cnt_reg == CNT_MAX) begin
              state_next = PRESSED;
              ev         = 1'b1;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
          PRESSED: begin
            if (!sync2_reg) begin
              state_next = RELEASE_WAIT;
              cnt_next   = '0;
            end
          end
          RELEASE_WAIT: begin
            if (sync2_reg) begin
              state_next = PRESSED;
            end else if (cnt_reg == CNT_MAX) begin
              state_next = RELEASED;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
          default: begin
            state_next = RELEASED;
            cnt_next   = '0;
          end
        endcase
      end

      assign press_ev[gi] = ev;
    end
  endgenerate

  logic [14:0] duty_reg;
  logic [14:0] duty_next;
  logic        duty_upd_reg;
  logic        at_max_reg;
  logic        at_min_reg;
  logic [16:0] up_sum;

  // Two spare bits so duty + STEP never overflows before the clamp.
  assign up_sum = {2'b00, duty_reg} + {2'b00, STEP_D};

  // Simultaneous up and down events cancel out.
  always_comb begin
    duty_next = duty_reg;
    if (press_ev[0] && !press_ev[1]) begin
      duty_next = (up_sum > {2'b00, MAX_D}) ? MAX_D : up_sum[14:0];
    end else if (press_ev[1] && !press_ev[0]) begin
      duty_next = (duty_reg >= STEP_D) ? (duty_reg - STEP_D) : 15'd0;
    end
  end

  // Flags and the update pulse derive from duty_next so they change in
  // the same cycle as duty; a saturated event leaves duty_upd low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty_reg     <= INIT_D;
      duty_upd_reg <= 1'b0;
      at_max_reg   <= (INIT_D == MAX_D);
      at_min_reg   <= (INIT_D == 15'd0);
    end else begin
      duty_reg     <= duty_next;
      duty_upd_reg <= (duty_next != duty_reg);
      at_max_reg   <= (duty_next == MAX_D);
      at_min_reg   <= (duty_next == 15'd0);
    end
  end

  assign bus.duty     = duty_reg;
  assign bus.duty_upd = duty_upd_reg;
  assign bus.at_max   = at_max_reg;
  assign bus.at_min   = at_min_reg;

endmodule

// File: tb/tb_duty_step_ctrl.sv
// tb_duty_step_ctrl
//   Directed bench for duty_step_ctrl with DEB_CYCLES=8. dut_a starts at
//   13500, dut_b starts at 1000 for the down-to-zero scenario.
module tb_duty_step_ctrl;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  duty_step_ctrl_if ifa ();
  duty_step_ctrl_if ifb ();

  duty_step_ctrl #(
    .DEB_CYCLES(8), .STEP(2700), .MAX_DUTY(27000), .INIT_DUTY(13500)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );

  duty_step_ctrl #(
    .DEB_CYCLES(8), .STEP(2700), .MAX_DUTY(27000), .INIT_DUTY(1000)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count duty_upd pulses over n cycles; first_at is the cycle index
  // (1 = after the first rising edge) of the first pulse, -1 if none.
  task automatic watch(input int sel, input int n, output int pulses,
                       output int first_at);
    logic upd;
    pulses   = 0;
    first_at = -1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      upd = (sel == 0) ? ifa.duty_upd : ifb.duty_upd;
      if (upd === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = i;
      end
    end
  endtask

  // Hold the chosen buttons 50 cycles, then release and watch 24 more.
  task automatic press(input int sel, input logic up, input logic dn,
                       output int p_hold, output int first_at,
                       output int p_rel);
    int dummy;
    if (sel == 0) begin ifa.btn_up = up; ifa.btn_dn = dn; end
    else          begin ifb.btn_up = up; ifb.btn_dn = dn; end
    watch(sel, 50, p_hold, first_at);
    if (sel == 0) begin ifa.btn_up = 1'b0; ifa.btn_dn = 1'b0; end
    else          begin ifb.btn_up = 1'b0; ifb.btn_dn = 1'b0; end
    watch(sel, 24, p_rel, dummy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int bad;
    // rst is low from time 0
    repeat (3) @(negedge clk);
    tests_run++;
    if (ifa.duty !== 15'd13500 || ifa.duty_upd !== 1'b0 ||
        ifa.at_max !== 1'b0 || ifa.at_min !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_a: duty=%0d upd=%b max=%b min=%b, required 13500 0 0 0",
               ifa.duty, ifa.duty_upd, ifa.at_max, ifa.at_min);
    end
    tests_run++;
    if (ifb.duty !== 15'd1000 || ifb.at_min !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_b: duty=%0d min=%b, required 1000 0", ifb.duty, ifb.at_min);
    end
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ifa.duty !== 15'd13500 || ifa.duty_upd !== 1'b0 ||
          ifa.at_max !== 1'b0 || ifa.at_min !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("[TB] FAIL idle_100: %0d bad cycles, required 0", bad);
    end
    $display("[TB] reset/idle: duty=%0d bad_cycles=%0d", ifa.duty, bad);
  endtask

  task automatic test_glitch();
    int pulses, p2, fa;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      ifa.btn_up = ((i / 3) % 2 == 0);
      @(negedge clk);
      if (ifa.duty_upd === 1'b1) pulses++;
    end
    ifa.btn_up = 1'b0;
    watch(0, 20, p2, fa);
    pulses += p2;
    tests_run++;
    if (pulses !== 0 || ifa.duty !== 15'd13500) begin
      tests_failed++;
      $display("[TB] FAIL glitch: pulses=%0d duty=%0d, required 0 13500", pulses, ifa.duty);
    end
    $display("[TB] glitch train: pulses=%0d duty=%0d", pulses, ifa.duty);
  endtask

  task automatic test_clean_press();
    int ph, fa, pr;
    press(0, 1'b1, 1'b0, ph, fa, pr);
    tests_run++;
    if (ph !== 1 || fa < 10 || fa > 12) begin
      tests_failed++;
      $display("[TB] FAIL clean_pulse: pulses=%0d at=%0d, required 1 at 10..12", ph, fa);
    end
    tests_run++;
    if (ifa.duty !== 15'd16200 || ifa.at_max !== 1'b0 || ifa.at_min !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clean_duty: duty=%0d, required 16200", ifa.duty);
    end
    tests_run++;
    if (pr !== 0) begin
      tests_failed++;
      $display("[TB] FAIL release_pulse: pulses=%0d, required 0", pr);
    end
    $display("[TB] up press: pulses=%0d at=%0d release_pulses=%0d duty=%0d", ph, fa, pr, ifa.duty);
  endtask

  task automatic test_down_press();
    int ph, fa, pr;
    press(0, 1'b0, 1'b1, ph, fa, pr);
    tests_run++;
    if (ph !== 1 || pr !== 0 || ifa.duty !== 15'd13500) begin
      tests_failed++;
      $display("[TB] FAIL down_press: pulses=%0d/%0d duty=%0d, required 1/0 13500", ph, pr, ifa.duty);
    end
    $display("[TB] down press: pulses=%0d duty=%0d", ph, ifa.duty);
  endtask

  task automatic test_saturate_up();
    int exp_duty [6] = '{16200, 18900, 21600, 24300, 27000, 27000};
    int exp_puls [6] = '{1, 1, 1, 1, 1, 0};
    int ph, fa, pr;
    for (int k = 0; k < 6; k++) begin
      press(0, 1'b1, 1'b0, ph, fa, pr);
      tests_run++;
      if (ph !== exp_puls[k] || int'(ifa.duty) !== exp_duty[k] ||
          ifa.at_max !== (k >= 4)) begin
        tests_failed++;
        $display("[TB] FAIL sat_up_%0d: pulses=%0d duty=%0d max=%b, required %0d %0d %b",
                 k, ph, ifa.duty, ifa.at_max, exp_puls[k], exp_duty[k], (k >= 4));
      end
      $display("[TB] up press %0d: pulses=%0d duty=%0d at_max=%b", k + 1, ph, ifa.duty, ifa.at_max);
    end
  endtask

  task automatic test_down_to_min();
    int ph, fa, pr;
    press(1, 1'b0, 1'b1, ph, fa, pr);
    tests_run++;
    if (ph !== 1 || ifb.duty !== 15'd0 || ifb.at_min !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL down_min: pulses=%0d duty=%0d min=%b, required 1 0 1", ph, ifb.duty, ifb.at_min);
    end
    $display("[TB] down from 1000: pulses=%0d duty=%0d at_min=%b", ph, ifb.duty, ifb.at_min);
    press(1, 1'b0, 1'b1, ph, fa, pr);
    tests_run++;
    if (ph !== 0 || ifb.duty !== 15'd0 || ifb.at_min !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL down_sat: pulses=%0d duty=%0d, required 0 0", ph, ifb.duty);
    end
    $display("[TB] down at zero: pulses=%0d duty=%0d", ph, ifb.duty);
  endtask

  task automatic test_simultaneous();
    int ph, fa, pr;
    press(0, 1'b1, 1'b1, ph, fa, pr);
    tests_run++;
    if (ph !== 0 || pr !== 0 || ifa.duty !== 15'd13500) begin
      tests_failed++;
      $display("[TB] FAIL simultaneous: pulses=%0d duty=%0d, required 0 13500", ph + pr, ifa.duty);
    end
    $display("[TB] up+down together: pulses=%0d duty=%0d", ph + pr, ifa.duty);
  endtask

  task automatic test_reset_mid_debounce();
    int p, fa;
    int p_pre, fa_pre;
    ifa.btn_up = 1'b1;
    watch(0, 8, p_pre, fa_pre);   // PRESS_WAIT count reaches 5
    rst = 1'b0;
    ifa.btn_up = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    watch(0, 30, p, fa);
    tests_run++;
    if (p + p_pre !== 0 || ifa.duty !== 15'd13500) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid: pulses=%0d duty=%0d, required 0 13500", p + p_pre, ifa.duty);
    end
    $display("[TB] reset mid-debounce: pulses=%0d duty=%0d", p + p_pre, ifa.duty);
  endtask

  task automatic test_held_through_reset();
    int p, fa, p_pre, fa_pre, pr, fr;
    ifa.btn_up = 1'b1;
    watch(0, 6, p_pre, fa_pre);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    watch(0, 30, p, fa);
    ifa.btn_up = 1'b0;
    watch(0, 24, pr, fr);
    tests_run++;
    if (p_pre !== 0 || p !== 1 || pr !== 0 || fa < 10 || fa > 12 || ifa.duty !== 15'd16200) begin
      tests_failed++;
      $display("[TB] FAIL held_reset: pulses=%0d/%0d/%0d at=%0d duty=%0d, required 0/1/0 at 10..12 16200",
               p_pre, p, pr, fa, ifa.duty);
    end
    $display("[TB] held through reset: pulses=%0d at=%0d duty=%0d", p, fa, ifa.duty);
  endtask

  initial begin
    int watchdog_dummy;
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    ifa.btn_up   = 1'b0;
    ifa.btn_dn   = 1'b0;
    ifb.btn_up   = 1'b0;
    ifb.btn_dn   = 1'b0;
    watchdog_dummy = 0;

    test_reset();
    test_glitch();
    test_clean_press();
    test_down_press();
    do_reset();
    test_saturate_up();
    test_down_to_min();
    do_reset();
    test_simultaneous();
    test_reset_mid_debounce();
    test_held_through_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
